xadc_drp_sequencer: RTL and testbench



---
 rtl/xadc_drp_sequencer_pkg.sv | 18 +
 rtl/xadc_drp_sequencer_if.sv | 11 +
 rtl/xadc_drp_sequencer_sat_counter8.sv | 18 +
 rtl/xadc_drp_sequencer.sv | 125 ++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xadc_drp_sequencer_pkg.sv
// Shared types and DRP constants for the XADC aux-channel sequencer.
package xadc_pkg;
   localparam int DRP_DW = 16;
   localparam int DRP_AW = 7;

   localparam logic [DRP_AW-1:0] DRP_ADDR_VAUX2  = 7'h12;
   localparam logic [DRP_AW-1:0] DRP_ADDR_VAUX3  = 7'h13;
   localparam logic [DRP_AW-1:0] DRP_ADDR_VAUX10 = 7'h1A;
   localparam logic [DRP_AW-1:0] DRP_ADDR_VAUX11 = 7'h1B;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_L  = 3'd1,
      WAIT_L = 3'd2,
      REQ_R  = 3'd3,
      WAIT_R = 3'd4
   } state_e;
endpackage

// File: rtl/xadc_drp_sequencer_if.sv
// DRP-side bundle between the sequencer (master) and one XADC instance (slave).
interface xadc_drp_sequencer_if;
   logic                         eoc_in;
   logic                         drdy_in;
   logic [xadc_pkg::DRP_DW-1:0]  do_in;
   logic                         den_out;
   logic [xadc_pkg::DRP_AW-1:0]  daddr_out;

   modport master (input eoc_in, drdy_in, do_in, output den_out, daddr_out);
   modport slave  (output eoc_in, drdy_in, do_in, input den_out, daddr_out);
endinterface

// File: rtl/xadc_drp_sequencer_sat_counter8.sv
// 8-bit event counter that sticks at 8'hFF instead of wrapping.
module sat_counter8 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   output logic [7:0] cnt_o
);
   logic [7:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else if (inc_i && (cnt_q != 8'hFF))
         cnt_q <= cnt_q + 8'd1;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/xadc_drp_sequencer.sv
// Reads the left then right aux result over DRP on every eoc and presents
// registered samples with strobes; counts DRP timeouts and dropped eoc pulses.
module xadc_drp_sequencer
   import xadc_pkg::*;
#(
   parameter logic [DRP_AW-1:0] ADDR_L  = DRP_ADDR_VAUX3,
   parameter logic [DRP_AW-1:0] ADDR_R  = DRP_ADDR_VAUX2,
   parameter int                TIMEOUT = 64
) (
   input  logic                 CLK100MHZ,
   input  logic                 reset_in,
   xadc_drp_sequencer_if.master drp,
   output logic [DRP_DW-1:0]    sample_l,
   output logic [DRP_DW-1:0]    sample_r,
   output logic                 valid_l,
   output logic                 valid_r,
   output logic                 pair_valid,
   output logic [7:0]           timeout_cnt,
   output logic [7:0]           overrun_cnt,
   output logic                 busy
);
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_e              state_q;
   logic [7:0]          timer_q;
   logic                den_q, busy_q;
   logic [DRP_AW-1:0]   daddr_q;
   logic [DRP_DW-1:0]   sample_l_q, sample_r_q;
   logic                valid_l_q, valid_r_q, pair_q;
   logic                in_wait, tmo_hit, ovr_hit;

   always_comb begin
      in_wait = (state_q == WAIT_L) || (state_q == WAIT_R);
      // drdy on the last timer cycle still wins over the timeout
      tmo_hit = in_wait && !drp.drdy_in && (timer_q == TMO_LAST);
      ovr_hit = drp.eoc_in && (state_q != IDLE);
   end

   always_ff @(posedge CLK100MHZ or posedge reset_in) begin
      if (reset_in) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         den_q      <= 1'b0;
         busy_q     <= 1'b0;
         daddr_q    <= ADDR_L;
         sample_l_q <= '0;
         sample_r_q <= '0;
         valid_l_q  <= 1'b0;
         valid_r_q  <= 1'b0;
         pair_q     <= 1'b0;
      end else begin
         den_q     <= 1'b0;
         valid_l_q <= 1'b0;
         valid_r_q <= 1'b0;
         pair_q    <= 1'b0;
         case (state_q)
            IDLE: if (drp.eoc_in) begin
               state_q <= REQ_L;
               den_q   <= 1'b1;
               daddr_q <= ADDR_L;
               busy_q  <= 1'b1;
            end
            REQ_L: begin
               timer_q <= '0;
               state_q <= WAIT_L;
            end
            WAIT_L: if (drp.drdy_in) begin
               sample_l_q <= drp.do_in;
               valid_l_q  <= 1'b1;
               state_q    <= REQ_R;
               den_q      <= 1'b1;
               daddr_q    <= ADDR_R;
            end else if (tmo_hit) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end else begin
               timer_q <= timer_q + 8'd1;
            end
            REQ_R: begin
               timer_q <= '0;
               state_q <= WAIT_R;
            end
            WAIT_R: if (drp.drdy_in) begin
               sample_r_q <= drp.do_in;
               valid_r_q  <= 1'b1;
               pair_q     <= 1'b1;
               state_q    <= IDLE;
               busy_q     <= 1'b0;
            end else if (tmo_hit) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end else begin
               timer_q <= timer_q + 8'd1;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   sat_counter8 u_tmo_cnt (
      .clk_i (CLK100MHZ),
      .rst_i (reset_in),
      .inc_i (tmo_hit),
      .cnt_o (timeout_cnt)
   );

   sat_counter8 u_ovr_cnt (
      .clk_i (CLK100MHZ),
      .rst_i (reset_in),
      .inc_i (ovr_hit),
      .cnt_o (overrun_cnt)
   );

   assign drp.den_out   = den_q;
   assign drp.daddr_out = daddr_q;
   assign sample_l      = sample_l_q;
   assign sample_r      = sample_r_q;
   assign valid_l       = valid_l_q;
   assign valid_r       = valid_r_q;
   assign pair_valid    = pair_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Bench: behavioural DRP slave with scoreboard queues, directed corner cases
// and a long randomized-latency run.
module tb_xadc_drp_sequencer;
   localparam logic [6:0] A_L = 7'h13;
   localparam logic [6:0] A_R = 7'h12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        eoc = 1'b0;
   logic        s_drdy = 1'b0, f_drdy = 1'b0;
   logic [15:0] s_do = '0, f_do = '0;
   logic [15:0] sample_l, sample_r;
   logic        valid_l, valid_r, pair_valid, busy;
   logic [7:0]  timeout_cnt, overrun_cnt;

   xadc_drp_sequencer_if drp ();
   assign drp.eoc_in  = eoc;
   assign drp.drdy_in = s_drdy | f_drdy;
   assign drp.do_in   = f_drdy ? f_do : s_do;

   xadc_drp_sequencer #(.ADDR_L(A_L), .ADDR_R(A_R), .TIMEOUT(64)) dut (
      .CLK100MHZ   (clk),
      .reset_in    (rst),
      .drp         (drp),
      .sample_l    (sample_l),
      .sample_r    (sample_r),
      .valid_l     (valid_l),
      .valid_r     (valid_r),
      .pair_valid  (pair_valid),
      .timeout_cnt (timeout_cnt),
      .overrun_cnt (overrun_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int nchk = 0, nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // slave model controls
   bit slave_en = 1'b1, drop_l = 1'b0, rand_lat = 1'b0, directed = 1'b0;
   int fix_lat = 2;
   logic [15:0] exp_l[$], exp_r[$];
   logic [15:0] last_l = '0, last_r = '0;
   int nl = 0, nr = 0, np = 0;

   // DRP slave: answers each den after lat cycles; responses become scoreboard entries
   initial begin
      bit          pend;
      logic [6:0]  a;
      logic [15:0] d;
      int          lat;
      forever begin
         @(negedge clk);
         pend = drp.den_out && slave_en;
         while (pend) begin
            pend = 1'b0;
            a = drp.daddr_out;
            if (!(drop_l && a == A_L)) begin
               lat = rand_lat ? int'($urandom_range(1, 6)) : fix_lat;
               d = directed ? ((a == A_L) ? 16'hA5A0 : 16'h5A50) : 16'($urandom);
               repeat (lat) @(negedge clk);
               if (slave_en) begin
                  s_drdy = 1'b1;
                  s_do   = d;
                  if (a == A_L) exp_l.push_back(d); else exp_r.push_back(d);
               end
               @(negedge clk);
               s_drdy = 1'b0;
               pend = drp.den_out && slave_en;
            end
         end
      end
   end

   // output monitor
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         if (valid_l) begin
            nl++;
            if (exp_l.size() > 0) begin
               e = exp_l.pop_front(); last_l = e;
               chk("sample_l", sample_l, e);
            end else chk("spurious_valid_l", 1, 0);
         end
         if (valid_r) begin
            nr++;
            if (exp_r.size() > 0) begin
               e = exp_r.pop_front(); last_r = e;
               chk("sample_r", sample_r, e);
            end else chk("spurious_valid_r", 1, 0);
         end
         if (pair_valid) begin
            np++;
            chk("pair_with_valid_r", valid_r, 1);
         end
      end
   end

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy && n < max) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sl"}, sample_l, 0);
      chk({tag, "_sr"}, sample_r, 0);
      chk({tag, "_v"}, {valid_l, valid_r, pair_valid, busy, drp.den_out}, 0);
      chk({tag, "_cnt"}, {timeout_cnt, overrun_cnt}, 0);
      chk({tag, "_daddr"}, drp.daddr_out, A_L);
   endtask

   initial begin
      int den_l_c, den_r_c, vl_c, pv_c, bcnt, np0, nl0, nr0, tmo_exp;
      bit found;

      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst = 1'b0;
      @(negedge clk);

      // 1: basic pair, 2-cycle DRP response, cycle-accurate timing
      directed = 1'b1; fix_lat = 2;
      den_l_c = -1; den_r_c = -1; vl_c = -1; pv_c = -1;
      eoc = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         eoc = 1'b0;
         if (drp.den_out && drp.daddr_out == A_L && den_l_c < 0) den_l_c = c;
         if (drp.den_out && drp.daddr_out == A_R && den_r_c < 0) den_r_c = c;
         if (valid_l && vl_c < 0) begin vl_c = c; chk("t1_sl", sample_l, 16'hA5A0); end
         if (pair_valid && pv_c < 0) begin pv_c = c; chk("t1_sr", sample_r, 16'h5A50); end
      end
      chk("t1_den_l_cycle", den_l_c, 1);
      chk("t1_valid_l_cycle", vl_c, 4);
      chk("t1_den_r_cycle", den_r_c, 4);
      chk("t1_pair_cycle", pv_c, 7);
      directed = 1'b0;

      // 2: no drdy for left read -> timeout after 64 wait cycles
      drop_l = 1'b1;
      nl0 = nl; nr0 = nr; bcnt = 0;
      eoc = 1'b1;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         eoc = 1'b0;
         if (busy) bcnt++; else break;
      end
      chk("t2_busy_cycles", bcnt, 65);
      chk("t2_timeout_cnt", timeout_cnt, 1);
      chk("t2_sl_hold", sample_l, 16'hA5A0);
      chk("t2_sr_hold", sample_r, 16'h5A50);
      chk("t2_no_valid", (nl - nl0) + (nr - nr0), 0);
      drop_l = 1'b0;

      // 3: three eoc pulses during an outstanding read
      fix_lat = 6; np0 = np;
      eoc = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         eoc = (c == 2 || c == 5 || c == 9);
      end
      chk("t3_overrun", overrun_cnt, 3);
      chk("t3_one_pair", np - np0, 1);
      // eoc in the cycle the right drdy lands still counts as overrun
      fix_lat = 2; np0 = np;
      eoc = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         eoc = (c == 6);
      end
      chk("t3_overrun_edge", overrun_cnt, 4);
      chk("t3_edge_pair", np - np0, 1);
      chk("t3_edge_idle", busy, 0);

      // 4: drdy held high in IDLE is ignored, then saturate timeout_cnt
      nl0 = nl; nr0 = nr;
      f_do = 16'h1234; f_drdy = 1'b1;
      repeat (40) @(negedge clk);
      f_drdy = 1'b0;
      @(negedge clk);
      chk("t4_idle_drdy_novalid", (nl - nl0) + (nr - nr0), 0);
      chk("t4_idle_drdy_sl", sample_l, last_l);
      chk("t4_idle_drdy_busy", busy, 0);
      drop_l = 1'b1; tmo_exp = 1;
      for (int i = 0; i < 300; i++) begin
         eoc = 1'b1;
         @(negedge clk);
         eoc = 1'b0;
         wait_idle(100);
         tmo_exp = (tmo_exp < 255) ? tmo_exp + 1 : 255;
         chk("t4_timeout_sat", timeout_cnt, tmo_exp);
      end
      drop_l = 1'b0;
      chk("t4_overrun_kept", overrun_cnt, 4);

      // 5: reset during WAIT_R, late drdy after release
      fix_lat = 2; found = 1'b0;
      eoc = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         eoc = 1'b0;
         if (drp.den_out && drp.daddr_out == A_R) begin found = 1'b1; break; end
      end
      chk("t5_reach_req_r", found, 1);
      slave_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("t5_rst");
      last_l = '0; last_r = '0;
      rst = 1'b0;
      nl0 = nl; nr0 = nr;
      @(negedge clk);
      f_do = 16'hBEEF; f_drdy = 1'b1;
      @(negedge clk);
      f_drdy = 1'b0;
      repeat (8) @(negedge clk);
      chk("t5_late_drdy_ignored", (nl - nl0) + (nr - nr0), 0);
      chk("t5_idle", busy, 0);
      chk("t5_sl_zero", sample_l, 0);
      slave_en = 1'b1; np0 = np;
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      wait_idle(50);
      @(negedge clk);
      chk("t5_pair_after", np - np0, 1);
      chk("t5_sr_after", sample_r, last_r);

      // 6: 1000 conversions, eoc every 20 cycles, random 1..6 latency
      rand_lat = 1'b1; np0 = np;
      for (int i = 0; i < 1000; i++) begin
         eoc = 1'b1;
         @(negedge clk);
         eoc = 1'b0;
         repeat (19) @(negedge clk);
      end
      wait_idle(50);
      repeat (2) @(negedge clk);
      chk("t6_pairs", np - np0, 1000);
      chk("t6_overrun", overrun_cnt, 0);
      chk("t6_timeout", timeout_cnt, 0);
      chk("t6_queues_drained", exp_l.size() + exp_r.size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
